// File: rtl/decode_if.sv
// IF/ID-to-ID/EX bundle for the decode stage: decoded-instruction inputs,
// write-back port, pipeline control, and the registered ID/EX outputs.
interface decode_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 12
);
  logic              if_valid;
  logic [31:0]       inst;
  logic [DATA_W-1:0] pc;
  logic [CTRL_W-1:0] ctrl;
  logic [2:0]        imm_sel;
  logic              reg2loc;
  logic              mem_read;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              ex_ready;

  logic              stall_if;
  logic              ex_valid;
  logic              ex_mem_read;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_rn_data;
  logic [DATA_W-1:0] ex_rm_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_br_target;
  logic [REG_AW-1:0] ex_rn;
  logic [REG_AW-1:0] ex_rm;
  logic [REG_AW-1:0] ex_rd;

  // Handshake: ID/EX contents transfer to EX on a rising edge where
  // ex_valid=1 and ex_ready=1; while ex_valid=1 and ex_ready=0 they are held
  // stable and IF/ID is stalled. stall_if tells IF to hold PC and IF/ID.
  modport master (
    output if_valid, inst, pc, ctrl, imm_sel, reg2loc, mem_read,
           wb_we, wb_addr, wb_data, flush, ex_ready,
    input  stall_if, ex_valid, ex_mem_read, ex_ctrl, ex_rn_data, ex_rm_data,
           ex_imm, ex_br_target, ex_rn, ex_rm, ex_rd
  );

  modport slave (
    input  if_valid, inst, pc, ctrl, imm_sel, reg2loc, mem_read,
           wb_we, wb_addr, wb_data, flush, ex_ready,
    output stall_if, ex_valid, ex_mem_read, ex_ctrl, ex_rn_data, ex_rm_data,
           ex_imm, ex_br_target, ex_rn, ex_rm, ex_rd
  );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: write-first register file, immediate generation, branch
// target, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_p #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 12
) (
  input logic    clk,
  input logic    reset,
  decode_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] ZR = REG_AW'(NREG - 1);

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] br_target;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;
  } idex_t;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  idex_t             ex_q;
  idex_t             ex_d;

  logic [REG_AW-1:0] rn_addr, rm_addr, rd_addr;
  logic [DATA_W-1:0] rn_data, rm_data, imm;
  logic              hazard, hold;
  logic              unused_inst_bits;

  assign unused_inst_bits = ^bus.inst[31:26];

  assign rn_addr = REG_AW'(bus.inst[9:5]);
  assign rd_addr = REG_AW'(bus.inst[4:0]);
  assign rm_addr = bus.reg2loc ? REG_AW'(bus.inst[4:0]) : REG_AW'(bus.inst[20:16]);

  // Reads bypass the same-cycle write-back so ID sees the freshest value.
  always_comb begin
    rn_data = regs_q[rn_addr];
    if (rn_addr == ZR) rn_data = '0;
    else if (bus.wb_we && bus.wb_addr == rn_addr) rn_data = bus.wb_data;
  end

  always_comb begin
    rm_data = regs_q[rm_addr];
    if (rm_addr == ZR) rm_data = '0;
    else if (bus.wb_we && bus.wb_addr == rm_addr) rm_data = bus.wb_data;
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_we && bus.wb_addr != ZR) regs_d[bus.wb_addr] = bus.wb_data;
  end

  always_comb begin
    imm = '0;
    case (bus.imm_sel)
      3'b001:  imm = {{(DATA_W-12){1'b0}}, bus.inst[21:10]};
      3'b010:  imm = {{(DATA_W-28){bus.inst[25]}}, bus.inst[25:0], 2'b00};
      3'b011:  imm = {{(DATA_W-21){bus.inst[23]}}, bus.inst[23:5], 2'b00};
      3'b100:  imm = {{(DATA_W-9){bus.inst[20]}}, bus.inst[20:12]};
      default: imm = '0;
    endcase
  end

  assign hold   = ex_q.valid && !bus.ex_ready;
  assign hazard = bus.if_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != ZR) &&
                  ((ex_q.rd == rn_addr) || (ex_q.rd == rm_addr));

  assign bus.stall_if = (hazard || hold) && !bus.flush;

  // Flush beats hold so a taken branch can kill an instruction parked in ID/EX.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (hazard || !bus.if_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.mem_read  = bus.mem_read;
      ex_d.ctrl      = bus.ctrl;
      ex_d.rn_data   = rn_data;
      ex_d.rm_data   = rm_data;
      ex_d.imm       = imm;
      ex_d.br_target = bus.pc + imm;
      ex_d.rn        = rn_addr;
      ex_d.rm        = rm_addr;
      ex_d.rd        = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= '0;
      regs_q <= '{default: '0};
    end else begin
      ex_q   <= ex_d;
      regs_q <= regs_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.ex_rn_data   = ex_q.rn_data;
  assign bus.ex_rm_data   = ex_q.rm_data;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_br_target = ex_q.br_target;
  assign bus.ex_rn        = ex_q.rn;
  assign bus.ex_rm        = ex_q.rm;
  assign bus.ex_rd        = ex_q.rd;
endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: directed scenarios plus randomized
// traffic compared against a behavioural model of the decode stage.
module tb_decode_stage_p;
  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic [11:0] ctrl;
    logic [63:0] rn_data;
    logic [63:0] rm_data;
    logic [63:0] imm;
    logic [63:0] br_target;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
  } ex_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  decode_if #(.DATA_W(64), .REG_AW(5), .CTRL_W(12)) bus ();

  decode_stage_p #(.DATA_W(64), .REG_AW(5), .CTRL_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_regs [32];
  ex_t         m_ex;
  logic        exp_stall;
  logic        obs_stall;

  function automatic ex_t obs();
    ex_t o;
    o.valid = bus.ex_valid;       o.mem_read = bus.ex_mem_read;
    o.ctrl = bus.ex_ctrl;         o.rn_data = bus.ex_rn_data;
    o.rm_data = bus.ex_rm_data;   o.imm = bus.ex_imm;
    o.br_target = bus.ex_br_target;
    o.rn = bus.ex_rn;  o.rm = bus.ex_rm;  o.rd = bus.ex_rd;
    return o;
  endfunction

  function automatic logic [63:0] m_imm(input logic [2:0] sel, input logic [31:0] ins);
    longint v;
    case (sel)
      3'b001: v = longint'(ins[21:10]);
      3'b010: v = (longint'(ins[25:0]) - (ins[25] ? (longint'(1) << 26) : 0)) * 4;
      3'b011: v = (longint'(ins[23:5]) - (ins[23] ? (longint'(1) << 19) : 0)) * 4;
      3'b100: v = longint'(ins[20:12]) - (ins[20] ? (longint'(1) << 9) : 0);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [4:0] m_rm_addr();
    return bus.reg2loc ? bus.inst[4:0] : bus.inst[20:16];
  endfunction

  function automatic logic m_hazard();
    return bus.if_valid && m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd31 &&
           (m_ex.rd == bus.inst[9:5] || m_ex.rd == m_rm_addr());
  endfunction

  function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [4:0] rn,
                                          input logic [4:0] rm);
    logic [31:0] r;
    r = $urandom;
    r[4:0] = rd;  r[9:5] = rn;  r[20:16] = rm;
    return r;
  endfunction

  // Advance one clock: sample stall before the edge, update the model, settle.
  task automatic tick();
    ex_t  nx;
    logic haz;
    #2;
    haz       = m_hazard();
    exp_stall = (haz || (m_ex.valid && !bus.ex_ready)) && !bus.flush;
    obs_stall = bus.stall_if;
    if (reset || bus.flush) nx = '0;
    else if (m_ex.valid && !bus.ex_ready) nx = m_ex;
    else if (haz || !bus.if_valid) nx = '0;
    else begin
      nx.valid = 1'b1;  nx.mem_read = bus.mem_read;  nx.ctrl = bus.ctrl;
      nx.rn = bus.inst[9:5];  nx.rm = m_rm_addr();  nx.rd = bus.inst[4:0];
      nx.rn_data = m_read(nx.rn);  nx.rm_data = m_read(nx.rm);
      nx.imm = m_imm(bus.imm_sel, bus.inst);
      nx.br_target = bus.pc + nx.imm;
    end
    if (reset) for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    else if (bus.wb_we && bus.wb_addr != 5'd31) m_regs[bus.wb_addr] = bus.wb_data;
    @(posedge clk);
    m_ex = nx;
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0;  bus.if_valid = 1'b0;  bus.flush = 1'b0;  bus.ex_ready = 1'b1;
    bus.wb_we = 1'b0;  bus.wb_addr = '0;  bus.wb_data = '0;  bus.mem_read = 1'b0;
    bus.reg2loc = 1'b0;  bus.imm_sel = 3'b000;  bus.ctrl = '0;  bus.pc = '0;
    bus.inst = '0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;  bus.wb_we = 1'b1;  bus.wb_addr = 5'd3;  bus.wb_data = {$urandom, $urandom} | 64'h1;
    bus.if_valid = 1'b1;  bus.inst = mk_inst(5'd3, 5'd3, 5'd3);  bus.ctrl = 12'hABC;
    tick();
    n_tests++;
    if (obs() !== '0) begin n_fail++; $display("FAIL reset_ex: got %h want 0", obs()); end
    n_tests++;
    if (bus.stall_if !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_if); end
    reset = 1'b0;  bus.wb_we = 1'b0;  bus.inst = mk_inst(5'd1, 5'd3, 5'd3);
    tick();
    n_tests++;
    if (bus.ex_rn_data !== 64'd0) begin n_fail++; $display("FAIL reset_wb_ignored: got %h want 0", bus.ex_rn_data); end
    n_tests++;
    if (obs() !== m_ex) begin n_fail++; $display("FAIL reset_first_load: got %h want %h", obs(), m_ex); end
  endtask

  task automatic test_write_first();
    set_idle();
    bus.wb_we = 1'b1;  bus.wb_addr = 5'd3;  bus.wb_data = 64'h1234;
    bus.if_valid = 1'b1;  bus.inst = mk_inst(5'd7, 5'd3, 5'd0);  bus.ctrl = 12'h055;
    tick();
    n_tests++;
    if (bus.ex_rn_data !== 64'h1234) begin n_fail++; $display("FAIL write_first: got %h want 1234", bus.ex_rn_data); end
    n_tests++;
    if (obs() !== m_ex) begin n_fail++; $display("FAIL write_first_ex: got %h want %h", obs(), m_ex); end
    bus.wb_we = 1'b0;  bus.inst = mk_inst(5'd8, 5'd0, 5'd3);
    tick();
    n_tests++;
    if (bus.ex_rm_data !== 64'h1234) begin n_fail++; $display("FAIL reg_persist: got %h want 1234", bus.ex_rm_data); end
  endtask

  task automatic test_load_use();
    logic [63:0] d;
    set_idle();
    d = {$urandom, $urandom};
    bus.if_valid = 1'b1;  bus.mem_read = 1'b1;  bus.inst = mk_inst(5'd5, 5'd1, 5'd2);
    tick();
    n_tests++;
    if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd5) begin
      n_fail++; $display("FAIL load_in_ex: got mr=%b rd=%0d want mr=1 rd=5", bus.ex_mem_read, bus.ex_rd);
    end
    bus.mem_read = 1'b0;  bus.inst = mk_inst(5'd6, 5'd5, 5'd2);
    bus.wb_we = 1'b1;  bus.wb_addr = 5'd5;  bus.wb_data = d;
    tick();
    n_tests++;
    if (obs_stall !== 1'b1 || bus.ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_use_bubble: got stall=%b valid=%b want stall=1 valid=0", obs_stall, bus.ex_valid);
    end
    bus.wb_we = 1'b0;
    tick();
    n_tests++;
    if (obs_stall !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_rn !== 5'd5 || bus.ex_rn_data !== d) begin
      n_fail++; $display("FAIL load_use_resume: got stall=%b valid=%b rn=%0d data=%h want 0 1 5 %h",
                         obs_stall, bus.ex_valid, bus.ex_rn, bus.ex_rn_data, d);
    end
  endtask

  task automatic test_x31();
    set_idle();
    bus.if_valid = 1'b1;  bus.mem_read = 1'b1;  bus.inst = mk_inst(5'd31, 5'd1, 5'd2);
    tick();
    bus.mem_read = 1'b0;  bus.inst = mk_inst(5'd4, 5'd31, 5'd31);
    bus.wb_we = 1'b1;  bus.wb_addr = 5'd31;  bus.wb_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    n_tests++;
    if (obs_stall !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_rn_data !== 64'd0 || bus.ex_rm_data !== 64'd0) begin
      n_fail++; $display("FAIL x31_no_stall: got stall=%b valid=%b rn=%h rm=%h want 0 1 0 0",
                         obs_stall, bus.ex_valid, bus.ex_rn_data, bus.ex_rm_data);
    end
    bus.wb_we = 1'b0;
    tick();
    n_tests++;
    if (bus.ex_rn_data !== 64'd0) begin n_fail++; $display("FAIL x31_write_hidden: got %h want 0", bus.ex_rn_data); end
  endtask

  task automatic test_hold_flush();
    ex_t held;
    set_idle();
    bus.if_valid = 1'b1;  bus.inst = mk_inst(5'd9, 5'd3, 5'd4);  bus.ctrl = 12'h3C3;
    bus.imm_sel = 3'b001;  bus.pc = 64'h40;
    tick();
    held = m_ex;
    for (int i = 0; i < 3; i++) begin
      bus.ex_ready = 1'b0;  bus.inst = mk_inst(5'($urandom_range(0, 30)), 5'd1, 5'd2);
      bus.ctrl = 12'($urandom);
      tick();
      n_tests++;
      if (obs_stall !== 1'b1 || obs() !== held) begin
        n_fail++; $display("FAIL hold_cycle%0d: got stall=%b ex=%h want 1 %h", i, obs_stall, obs(), held);
      end
    end
    bus.flush = 1'b1;
    tick();
    n_tests++;
    if (obs_stall !== 1'b0 || bus.ex_valid !== 1'b0 || obs() !== '0) begin
      n_fail++; $display("FAIL flush_during_hold: got stall=%b ex=%h want 0 0", obs_stall, obs());
    end
  endtask

  task automatic test_imm_wrap();
    logic [31:0] ins;
    set_idle();
    bus.if_valid = 1'b1;
    ins = mk_inst(5'd1, 5'd2, 5'd3);  ins[23:5] = 19'h7FFFF;
    bus.inst = ins;  bus.imm_sel = 3'b011;  bus.pc = 64'h1000;
    tick();
    n_tests++;
    if (bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC || bus.ex_br_target !== 64'hFFC) begin
      n_fail++; $display("FAIL cb_imm: got imm=%h tgt=%h want fffffffffffffffc ffc", bus.ex_imm, bus.ex_br_target);
    end
    ins = mk_inst(5'd1, 5'd2, 5'd3);  ins[25:0] = 26'd2;
    bus.inst = ins;  bus.imm_sel = 3'b010;  bus.pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    n_tests++;
    if (bus.ex_imm !== 64'd8 || bus.ex_br_target !== 64'h4) begin
      n_fail++; $display("FAIL b_wrap: got imm=%h tgt=%h want 8 4", bus.ex_imm, bus.ex_br_target);
    end
    for (int s = 0; s < 8; s++) begin
      bus.imm_sel = 3'(s);  bus.inst = mk_inst(5'd1, 5'd2, 5'd3);  bus.pc = {$urandom, $urandom};
      tick();
      n_tests++;
      if (obs() !== m_ex) begin n_fail++; $display("FAIL imm_sel%0d: got %h want %h", s, obs(), m_ex); end
    end
  endtask

  task automatic test_reset_during_stall();
    set_idle();
    bus.wb_we = 1'b1;  bus.wb_addr = 5'd3;  bus.wb_data = 64'h5555;
    bus.if_valid = 1'b1;  bus.mem_read = 1'b1;  bus.inst = mk_inst(5'd5, 5'd1, 5'd2);
    tick();
    bus.wb_we = 1'b0;  bus.mem_read = 1'b0;  bus.inst = mk_inst(5'd6, 5'd5, 5'd3);
    reset = 1'b1;
    tick();
    n_tests++;
    if (obs_stall !== 1'b1 || obs() !== '0) begin
      n_fail++; $display("FAIL reset_in_stall: got stall=%b ex=%h want 1 0", obs_stall, obs());
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (obs_stall !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_rm_data !== 64'd0) begin
      n_fail++; $display("FAIL after_reset_stall: got stall=%b valid=%b rm=%h want 0 1 0",
                         obs_stall, bus.ex_valid, bus.ex_rm_data);
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  task automatic test_random();
    set_idle();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.if_valid = ($urandom_range(0, 4) != 0);
      bus.inst = mk_inst(rnd_reg(), rnd_reg(), rnd_reg());
      bus.pc = {$urandom, $urandom};
      bus.ctrl = 12'($urandom);
      bus.imm_sel = 3'($urandom);
      bus.reg2loc = 1'($urandom);
      bus.mem_read = ($urandom_range(0, 2) == 0);
      bus.wb_we = 1'($urandom);
      bus.wb_addr = rnd_reg();
      bus.wb_data = {$urandom, $urandom};
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_tests++;
      if (obs_stall !== exp_stall || obs() !== m_ex) begin
        n_fail++; $display("FAIL random_c%0d: got stall=%b ex=%h want stall=%b ex=%h",
                           c, obs_stall, obs(), exp_stall, m_ex);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ex    = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    set_idle();
    test_reset();
    test_write_first();
    test_load_use();
    test_x31();
    test_hold_flush();
    test_imm_wrap();
    test_reset_during_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
